// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out feeder, MSB first, with a one-word holding buffer
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             enable,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic [15:0]      word_count
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic             hold_full_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [15:0]      word_count_nxt;
    logic             accept;
    logic             last_bit;
    logic             transfer;

    // Ready looks only at the registered flag, so hold never drains and refills on one edge.
    assign load_ready = reset & ~hold_full;

    always_comb begin
        accept         = load_valid & load_ready;
        last_bit       = (state == SHIFT) && enable && (cnt == LAST);
        transfer       = hold_full && ((state == IDLE) || last_bit);

        state_nxt      = state;
        sreg_nxt       = sreg;
        cnt_nxt        = cnt;
        hold_full_nxt  = hold_full;
        word_count_nxt = word_count;

        if (accept) begin
            hold_full_nxt = 1'b1;
        end

        if (last_bit) begin
            word_count_nxt = word_count + 16'd1;
        end

        if (transfer) begin
            sreg_nxt      = hold;
            cnt_nxt       = '0;
            hold_full_nxt = 1'b0;
            state_nxt     = SHIFT;
        end else if (last_bit) begin
            sreg_nxt  = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
        end else if ((state == SHIFT) && enable) begin
            sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
            cnt_nxt  = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            hold       <= '0;
            hold_full  <= 1'b0;
            sreg       <= '0;
            cnt        <= '0;
            word_count <= '0;
        end else begin
            state      <= state_nxt;
            hold_full  <= hold_full_nxt;
            sreg       <= sreg_nxt;
            cnt        <= cnt_nxt;
            word_count <= word_count_nxt;
            if (accept) begin
                hold <= load_data;
            end
        end
    end

    assign sout        = sreg[WIDTH-1];
    assign sout_valid  = (state == SHIFT);
    assign frame_start = sout_valid && (cnt == '0);

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed vector bench for piso_serializer at WIDTH=4 and WIDTH=8
module tb_piso_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  load_data;
    logic        load_valid;
    logic        load_ready;
    logic        enable;
    logic        sout;
    logic        sout_valid;
    logic        frame_start;
    logic [15:0] word_count;

    logic [7:0]  ld8;
    logic        lv8;
    logic        rdy8;
    logic        en8;
    logic        s8;
    logic        v8;
    logic        f8;
    logic [15:0] wc8;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .enable      (enable),
        .sout        (sout),
        .sout_valid  (sout_valid),
        .frame_start (frame_start),
        .word_count  (word_count)
    );

    piso_serializer #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .reset       (reset),
        .load_data   (ld8),
        .load_valid  (lv8),
        .load_ready  (rdy8),
        .enable      (en8),
        .sout        (s8),
        .sout_valid  (v8),
        .frame_start (f8),
        .word_count  (wc8)
    );

    typedef struct {
        logic        rst;
        logic        lv;
        logic [3:0]  ld;
        logic        en;
        logic        rdy;
        logic        s;
        logic        v;
        logic        f;
        logic [15:0] wc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic lv, input logic [3:0] ld, input logic en,
                       input logic rdy, input logic s, input logic v, input logic f,
                       input logic [15:0] wc);
        vec_t r;
        r.rst = rst; r.lv = lv; r.ld = ld; r.en = en;
        r.rdy = rdy; r.s = s; r.v = v; r.f = f; r.wc = wc;
        tbl.push_back(r);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later, well clear of the rising edge.
    task automatic drive(input logic rst, input logic lv, input logic [3:0] ld, input logic en);
        @(negedge clk);
        reset      = rst;
        load_valid = lv;
        load_data  = ld;
        enable     = en;
        #1;
    endtask

    task automatic expect4(input string nm, input logic rdy, input logic s, input logic v,
                           input logic f, input logic [15:0] wc);
        tests++;
        if ({load_ready, sout, sout_valid, frame_start, word_count} !== {rdy, s, v, f, wc}) begin
            failed++;
            $display("FAIL %s: got rdy=%b sout=%b vld=%b fs=%b wc=%0d, want rdy=%b sout=%b vld=%b fs=%b wc=%0d",
                     nm, load_ready, sout, sout_valid, frame_start, word_count, rdy, s, v, f, wc);
        end
    endtask

    task automatic expect8(input string nm, input logic rdy, input logic s, input logic v,
                           input logic f, input logic [15:0] wc);
        tests++;
        if ({rdy8, s8, v8, f8, wc8} !== {rdy, s, v, f, wc}) begin
            failed++;
            $display("FAIL %s: got rdy=%b sout=%b vld=%b fs=%b wc=%0d, want rdy=%b sout=%b vld=%b fs=%b wc=%0d",
                     nm, rdy8, s8, v8, f8, wc8, rdy, s, v, f, wc);
        end
    endtask

    initial begin
        int vcount;
        logic [7:0] w8;

        reset = 1'b0; load_valid = 1'b0; load_data = '0; enable = 1'b1;
        lv8 = 1'b0; ld8 = '0; en8 = 1'b0;

        // Single word 4'hA, then back-to-back 4'h9 / 4'h6 with load_valid held high.
        add(0, 0, 4'h0, 1,  0, 0, 0, 0, 16'd0);
        add(1, 1, 4'hA, 1,  1, 0, 0, 0, 16'd0);
        add(1, 0, 4'h0, 1,  0, 0, 0, 0, 16'd0);
        add(1, 0, 4'h0, 1,  1, 1, 1, 1, 16'd0);
        add(1, 0, 4'h0, 1,  1, 0, 1, 0, 16'd0);
        add(1, 0, 4'h0, 1,  1, 1, 1, 0, 16'd0);
        add(1, 0, 4'h0, 1,  1, 0, 1, 0, 16'd0);
        add(1, 0, 4'h0, 1,  1, 0, 0, 0, 16'd1);
        add(1, 1, 4'h9, 1,  1, 0, 0, 0, 16'd1);
        add(1, 1, 4'h6, 1,  0, 0, 0, 0, 16'd1);
        add(1, 1, 4'h6, 1,  1, 1, 1, 1, 16'd1);
        add(1, 0, 4'h0, 1,  0, 0, 1, 0, 16'd1);
        add(1, 0, 4'h0, 1,  0, 0, 1, 0, 16'd1);
        add(1, 0, 4'h0, 1,  0, 1, 1, 0, 16'd1);
        add(1, 0, 4'h0, 1,  1, 0, 1, 1, 16'd2);
        add(1, 0, 4'h0, 1,  1, 1, 1, 0, 16'd2);
        add(1, 0, 4'h0, 1,  1, 1, 1, 0, 16'd2);
        add(1, 0, 4'h0, 1,  1, 0, 1, 0, 16'd2);
        add(1, 0, 4'h0, 1,  1, 0, 0, 0, 16'd3);

        drive(0, 0, 4'h0, 1);
        drive(0, 0, 4'h0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].lv, tbl[i].ld, tbl[i].en);
            expect4($sformatf("tbl[%0d]", i), tbl[i].rdy, tbl[i].s, tbl[i].v, tbl[i].f, tbl[i].wc);
        end

        // Stall: 4'hC with enable low for 3 cycles while its second bit is on sout.
        vcount = 0;
        drive(1, 1, 4'hC, 1); expect4("stall_acc", 1, 0, 0, 0, 16'd3);
        drive(1, 0, 4'h0, 1); expect4("stall_xfer", 0, 0, 0, 0, 16'd3);
        drive(1, 0, 4'h0, 1); vcount += int'(sout_valid); expect4("stall_b0", 1, 1, 1, 1, 16'd3);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 4'h0, 0); vcount += int'(sout_valid);
            expect4($sformatf("stall_hold%0d", i), 1, 1, 1, 0, 16'd3);
        end
        drive(1, 0, 4'h0, 1); vcount += int'(sout_valid); expect4("stall_b1", 1, 1, 1, 0, 16'd3);
        drive(1, 0, 4'h0, 1); vcount += int'(sout_valid); expect4("stall_b2", 1, 0, 1, 0, 16'd3);
        drive(1, 0, 4'h0, 1); vcount += int'(sout_valid); expect4("stall_b3", 1, 0, 1, 0, 16'd3);
        drive(1, 0, 4'h0, 1); vcount += int'(sout_valid); expect4("stall_done", 1, 0, 0, 0, 16'd4);
        tests++;
        if (vcount != 7) begin
            failed++;
            $display("FAIL stall_vcount: got %0d valid cycles, want 7", vcount);
        end

        // Backpressure: 4'h3 and 4'h5 taken with enable low, 4'h7 refused.
        drive(1, 1, 4'h3, 0); expect4("bp_acc3", 1, 0, 0, 0, 16'd4);
        drive(1, 1, 4'h5, 0); expect4("bp_xfer3", 0, 0, 0, 0, 16'd4);
        drive(1, 1, 4'h5, 0); expect4("bp_acc5", 1, 0, 1, 1, 16'd4);
        drive(1, 1, 4'h7, 0); expect4("bp_full0", 0, 0, 1, 1, 16'd4);
        drive(1, 1, 4'h7, 0); expect4("bp_full1", 0, 0, 1, 1, 16'd4);
        drive(1, 0, 4'h0, 1); expect4("bp_3b0", 0, 0, 1, 1, 16'd4);
        drive(1, 0, 4'h0, 1); expect4("bp_3b1", 0, 0, 1, 0, 16'd4);
        drive(1, 0, 4'h0, 1); expect4("bp_3b2", 0, 1, 1, 0, 16'd4);
        drive(1, 0, 4'h0, 1); expect4("bp_3b3", 0, 1, 1, 0, 16'd4);
        drive(1, 0, 4'h0, 1); expect4("bp_5b0", 1, 0, 1, 1, 16'd5);
        drive(1, 0, 4'h0, 1); expect4("bp_5b1", 1, 1, 1, 0, 16'd5);
        drive(1, 0, 4'h0, 1); expect4("bp_5b2", 1, 0, 1, 0, 16'd5);
        drive(1, 0, 4'h0, 1); expect4("bp_5b3", 1, 1, 1, 0, 16'd5);
        drive(1, 0, 4'h0, 1); expect4("bp_idle0", 1, 0, 0, 0, 16'd6);
        drive(1, 0, 4'h0, 1); expect4("bp_idle1", 1, 0, 0, 0, 16'd6);

        // Reset on the third bit of 4'hF while 4'h1 waits in hold.
        drive(1, 1, 4'hF, 1); expect4("rst_accF", 1, 0, 0, 0, 16'd6);
        drive(1, 1, 4'h1, 1); expect4("rst_xferF", 0, 0, 0, 0, 16'd6);
        drive(1, 1, 4'h1, 1); expect4("rst_b0", 1, 1, 1, 1, 16'd6);
        drive(1, 0, 4'h0, 1); expect4("rst_b1", 0, 1, 1, 0, 16'd6);
        drive(0, 0, 4'h0, 1); expect4("rst_b2", 0, 1, 1, 0, 16'd6);
        drive(0, 1, 4'h7, 1); expect4("rst_low", 0, 0, 0, 0, 16'd0);
        drive(1, 0, 4'h0, 1); expect4("rst_rel", 1, 0, 0, 0, 16'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 4'h0, 1);
            expect4($sformatf("rst_quiet%0d", i), 1, 0, 0, 0, 16'd0);
        end

        // WIDTH=8 instance: 8'hB4 emitted MSB first.
        w8 = 8'hB4;
        @(negedge clk); lv8 = 1'b1; ld8 = w8; en8 = 1'b1; #1;
        expect8("w8_acc", 1, 0, 0, 0, 16'd0);
        @(negedge clk); lv8 = 1'b0; ld8 = '0; #1;
        expect8("w8_xfer", 0, 0, 0, 0, 16'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            expect8($sformatf("w8_b%0d", i), 1, w8[7-i], 1, (i == 0), 16'd0);
        end
        @(negedge clk); #1;
        expect8("w8_done", 1, 0, 0, 0, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
